// File: rtl/solver_cmd_sequencer_if.sv
// Bundle of command, solver and response signals for solver_cmd_sequencer.
// master: sequencer side. slave: command source, solver model, response sink.
interface solver_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [59:0] cmd_plain;
    logic [77:0] cmd_cipher;

    logic [1:0]  slv_work;
    logic [59:0] slv_data_80;
    logic [77:0] slv_data_96;
    logic [77:0] slv_out_96;
    logic [59:0] slv_out_80;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_op;
    logic [77:0] rsp_data;
    logic        rsp_err;
    logic [15:0] done_cnt;

    modport master (
        input  cmd_valid,
        output cmd_ready,
        input  cmd_op,
        input  cmd_plain,
        input  cmd_cipher,
        output slv_work,
        output slv_data_80,
        output slv_data_96,
        input  slv_out_96,
        input  slv_out_80,
        output rsp_valid,
        input  rsp_ready,
        output rsp_op,
        output rsp_data,
        output rsp_err,
        output done_cnt
    );

    modport slave (
        output cmd_valid,
        input  cmd_ready,
        output cmd_op,
        output cmd_plain,
        output cmd_cipher,
        input  slv_work,
        input  slv_data_80,
        input  slv_data_96,
        output slv_out_96,
        output slv_out_80,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_op,
        input  rsp_data,
        input  rsp_err,
        input  done_cnt
    );
endinterface

// File: rtl/solver_cmd_sequencer.sv
// Sequences one command at a time through a fixed-latency Solver and
// holds the result until downstream accepts it; counts retired responses.
// Ports: Clk, Rst_n (async, active-low), bus (master modport: cmd_*,
// slv_*, rsp_*, done_cnt).
module solver_cmd_sequencer #(
    parameter int unsigned LATENCY = 4
) (
    input  logic Clk,
    input  logic Rst_n,
    solver_cmd_sequencer_if.master bus
);

    if (LATENCY < 2 || LATENCY > 15) begin : g_bad_latency
        $error("solver_cmd_sequencer: LATENCY must be 2..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] OP_ENC  = 2'b00;
    localparam logic [1:0] OP_ILL  = 2'b11;
    localparam logic [1:0] WK_HOLD = 2'b11;
    localparam logic [3:0] CNT_LD  = 4'(LATENCY - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        cmd_ready_q;
    logic [1:0]  op_q;
    logic [1:0]  work_q;
    logic [59:0] data80_q;
    logic [77:0] data96_q;
    logic        rsp_valid_q;
    logic [1:0]  rsp_op_q;
    logic [77:0] rsp_data_q;
    logic [77:0] rsp_data_d;
    logic        rsp_err_q;
    logic [15:0] done_cnt_q;
    logic [15:0] done_cnt_d;
    logic        accept;

    // cmd_ready_q is high exactly while in IDLE, so it doubles as the
    // IDLE qualifier for the handshake.
    assign accept = bus.cmd_valid & cmd_ready_q;

    assign cnt_d      = cnt_q - 4'd1;
    assign done_cnt_d = done_cnt_q + 16'd1;

    // Encrypt returns the wide word; everything else is 60 bits wide.
    assign rsp_data_d = (op_q == OP_ENC) ? bus.slv_out_96
                                         : {18'b0, bus.slv_out_80};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            cmd_ready_q <= 1'b1;
            op_q        <= 2'b00;
            work_q      <= WK_HOLD;
            data80_q    <= 60'd0;
            data96_q    <= 78'd0;
            rsp_valid_q <= 1'b0;
            rsp_op_q    <= 2'b00;
            rsp_data_q  <= 78'd0;
            rsp_err_q   <= 1'b0;
            done_cnt_q  <= 16'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        if (bus.cmd_op == OP_ILL) begin
                            // Illegal ops never reach the Solver.
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_op_q    <= OP_ILL;
                            rsp_data_q  <= 78'd0;
                            state_q     <= RESP;
                        end else begin
                            op_q     <= bus.cmd_op;
                            work_q   <= bus.cmd_op;
                            data80_q <= bus.cmd_plain;
                            data96_q <= bus.cmd_cipher;
                            cnt_q    <= CNT_LD;
                            state_q  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (cnt_q == 4'd0) begin
                        rsp_data_q  <= rsp_data_d;
                        rsp_op_q    <= op_q;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        work_q      <= WK_HOLD;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        done_cnt_q  <= done_cnt_d;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    work_q      <= WK_HOLD;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.slv_work    = work_q;
    assign bus.slv_data_80 = data80_q;
    assign bus.slv_data_96 = data96_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_op      = rsp_op_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.done_cnt    = done_cnt_q;

endmodule
